// File: rtl/raisin64_pkg.sv
// Shared raisin64 definitions: register-file defaults, FSM state encoding
// and a small helper for the clear-sweep start entry.
package raisin64_pkg;

  // Architectural defaults for the raisin64 integer register file.
  localparam int unsigned RAISIN64_XLEN  = 64;
  localparam int unsigned RAISIN64_NREGS = 64;

  // Register-file control states: INIT runs the post-reset clear sweep.
  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  // First entry the clear sweep touches; r0 is skipped when hardwired to zero.
  function automatic int unsigned rf_first_entry(input int unsigned zero_reg);
    return (zero_reg != 0) ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// Single-write, single-registered-read storage bank.
// No reset on the array so it can map onto block RAM; contents are
// defined only after the owner has swept zeros through every entry.
// Ports:
//   clk    - rising-edge clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, sampled every cycle
//   rdata  - registered read data (old contents on same-address write)
module regfile_bank #(
  parameter  int unsigned XLEN  = 64,
  parameter  int unsigned NREGS = 64,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [NREGS];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port, read-before-write.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-back bypass, optional hardwired
// zero register, per-register pending scoreboard and a post-reset clear sweep.
// Ports:
//   clk       - sole clock, rising edge
//   rst_n     - synchronous active-low reset
//   rd_rn     - read register numbers, port k at [k*AW +: AW]
//   rd_data   - read data one cycle after rd_rn, port k at [k*XLEN +: XLEN]
//   rd_pend   - pending flag per read port, aligned with rd_data
//   w_en      - write-back enable (also clears pending for w_rn)
//   w_rn      - write-back register number
//   w_data    - write-back data
//   sb_set    - mark sb_rn pending (issue)
//   sb_rn     - register to mark pending
//   init_done - high once the clear sweep has completed
module regfile_mp
  import raisin64_pkg::*;
#(
  parameter  int unsigned XLEN     = RAISIN64_XLEN,
  parameter  int unsigned NREGS    = RAISIN64_NREGS,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_rn,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                w_en,
  input  logic [AW-1:0]       w_rn,
  input  logic [XLEN-1:0]     w_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_rn,
  output logic                init_done
);

  localparam bit            ZR    = (ZERO_REG != 0);
  localparam logic [AW-1:0] FIRST = AW'(rf_first_entry(ZERO_REG));
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  rf_state_e       state_q;
  logic [AW-1:0]   sweep_q;
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_nxt;

  logic            run_c;
  logic            sweep_c;
  logic            w_ok_c;
  logic            sb_ok_c;
  logic            bank_we;
  logic [AW-1:0]   bank_waddr;
  logic [XLEN-1:0] bank_wdata;

  // Control FSM and clear-sweep counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RF_INIT;
      sweep_q   <= FIRST;
      init_done <= 1'b0;
    end else begin
      case (state_q)
        RF_INIT: begin
          if (sweep_q == LAST) begin
            state_q   <= RF_RUN;
            init_done <= 1'b1;
          end else begin
            sweep_q <= sweep_q + AW'(1);
          end
        end
        RF_RUN: begin
          init_done <= 1'b1;
        end
        default: begin
          state_q   <= RF_INIT;
          sweep_q   <= FIRST;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Qualified write/issue requests; r0 traffic is dropped when hardwired.
  always_comb begin
    run_c   = rst_n && (state_q == RF_RUN);
    sweep_c = rst_n && (state_q == RF_INIT);
    w_ok_c  = run_c && w_en   && !(ZR && (w_rn  == '0));
    sb_ok_c = run_c && sb_set && !(ZR && (sb_rn == '0));
  end

  // Shared bank write port: sweep zeros in INIT, write-back in RUN.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = w_rn;
    bank_wdata = w_data;
    if (sweep_c) begin
      bank_we    = 1'b1;
      bank_waddr = sweep_q;
      bank_wdata = '0;
    end else if (w_ok_c) begin
      bank_we = 1'b1;
    end
  end

  // Scoreboard next state; set is applied after clear so it wins.
  always_comb begin
    pend_nxt = pend_q;
    if (w_ok_c) begin
      pend_nxt[w_rn] = 1'b0;
    end
    if (sb_ok_c) begin
      pend_nxt[sb_rn] = 1'b1;
    end
    if (!run_c) begin
      pend_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
    end
  end

  // One bank per read port, all written identically.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   rn_c;
    logic            zero_c;
    logic [XLEN-1:0] bank_q;
    logic            valid_q;
    logic            byp_q;
    logic [XLEN-1:0] byp_data_q;
    logic            pend_bit_q;

    assign rn_c   = rd_rn[k*AW +: AW];
    assign zero_c = ZR && (rn_c == '0);

    regfile_bank #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (rn_c),
      .rdata (bank_q)
    );

    // Per-port read-side flops: validity, bypass capture and pending flag.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q    <= 1'b0;
        byp_q      <= 1'b0;
        byp_data_q <= '0;
        pend_bit_q <= 1'b0;
      end else begin
        valid_q    <= run_c && !zero_c;
        byp_q      <= w_ok_c && (w_rn == rn_c);
        byp_data_q <= w_data;
        pend_bit_q <= run_c && !zero_c && pend_nxt[rn_c];
      end
    end

    // Select between flopped bypass data and the bank's read register.
    assign rd_data[k*XLEN +: XLEN] = !valid_q ? '0 :
                                     byp_q    ? byp_data_q : bank_q;
    assign rd_pend[k]              = pend_bit_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 64;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 6;

  logic                clk;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_rn;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;
  logic                w_en;
  logic [AW-1:0]       w_rn;
  logic [XLEN-1:0]     w_data;
  logic                sb_set;
  logic [AW-1:0]       sb_rn;
  logic                init_done;

  int errors = 0;
  int checks = 0;

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_rn     (rd_rn),
    .rd_data   (rd_data),
    .rd_pend   (rd_pend),
    .w_en      (w_en),
    .w_rn      (w_rn),
    .w_data    (w_data),
    .sb_set    (sb_set),
    .sb_rn     (sb_rn),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p0, input int p1);
    rd_rn = {AW'(p1), AW'(p0)};
  endtask

  task automatic idle();
    w_en   = 1'b0;
    sb_set = 1'b0;
  endtask

  task automatic do_write(input int rn, input logic [XLEN-1:0] d);
    w_en   = 1'b1;
    w_rn   = AW'(rn);
    w_data = d;
  endtask

  task automatic do_set(input int rn);
    sb_set = 1'b1;
    sb_rn  = AW'(rn);
  endtask

  // Counts edges until init_done rises, bounded.
  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle();
    w_rn = '0; w_data = '0; sb_rn = '0;
    set_rd(0, 0);
    tick(); tick();
    checks++;
    if (init_done !== 1'b0) begin
      errors++; $display("FAIL reset_init_done: got %b expected 0", init_done);
    end
    checks++;
    if (rd_data !== '0 || rd_pend !== '0) begin
      errors++; $display("FAIL reset_outputs: got data=%h pend=%b expected 0/00", rd_data, rd_pend);
    end
    rst_n = 1'b1;
    wait_init(n);
    checks++;
    if (n != 63) begin
      errors++; $display("FAIL sweep_length: got %0d expected 63", n);
    end
    for (int r = 0; r < 64; r += 2) begin
      set_rd(r, r + 1);
      tick();
      checks++;
      if (rd_data !== '0 || rd_pend !== '0) begin
        errors++; $display("FAIL cleared_r%0d: got data=%h pend=%b expected 0/00", r, rd_data, rd_pend);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5, 64'h0123_4567_89AB_CDEF);
    tick();
    idle();
    set_rd(5, 5);
    tick();
    checks++;
    if (rd_data[63:0] !== 64'h0123_4567_89AB_CDEF || rd_data[127:64] !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL read_r5: got %h expected 0123456789abcdef on both", rd_data);
    end
    do_write(6, 64'hFFFF_0000_8000_0001);
    tick();
    idle();
    set_rd(6, 5);
    tick();
    checks++;
    if (rd_data[63:0] !== 64'hFFFF_0000_8000_0001 || rd_data[127:64] !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL read_r6_r5: got %h expected 0123456789abcdef_ffff000080000001", rd_data);
    end
  endtask

  task automatic test_bypass();
    do_write(7, 64'hDEAD);
    set_rd(7, 7);
    tick();
    idle();
    checks++;
    if (rd_data[63:0] !== 64'hDEAD || rd_data[127:64] !== 64'hDEAD || rd_pend !== 2'b00) begin
      errors++; $display("FAIL bypass_r7: got data=%h pend=%b expected dead on both/00", rd_data, rd_pend);
    end
    tick();
    checks++;
    if (rd_data[63:0] !== 64'hDEAD) begin
      errors++; $display("FAIL stored_r7: got %h expected dead", rd_data[63:0]);
    end
  endtask

  task automatic test_zero_reg();
    do_write(0, 64'hFFFF);
    do_set(0);
    set_rd(0, 0);
    tick();
    idle();
    checks++;
    if (rd_data !== '0 || rd_pend !== 2'b00) begin
      errors++; $display("FAIL zero_same_cycle: got data=%h pend=%b expected 0/00", rd_data, rd_pend);
    end
    tick();
    checks++;
    if (rd_data !== '0 || rd_pend !== 2'b00) begin
      errors++; $display("FAIL zero_after: got data=%h pend=%b expected 0/00", rd_data, rd_pend);
    end
  endtask

  task automatic test_scoreboard();
    do_set(9);
    set_rd(9, 9);
    tick();
    idle();
    checks++;
    if (rd_pend !== 2'b11) begin
      errors++; $display("FAIL pend_set_bypass: got %b expected 11", rd_pend);
    end
    tick();
    checks++;
    if (rd_pend !== 2'b11) begin
      errors++; $display("FAIL pend_held: got %b expected 11", rd_pend);
    end
    do_write(9, 64'h99);
    do_set(9);
    tick();
    idle();
    checks++;
    if (rd_pend !== 2'b11 || rd_data[63:0] !== 64'h99) begin
      errors++; $display("FAIL pend_set_wins: got pend=%b data=%h expected 11/99", rd_pend, rd_data[63:0]);
    end
    do_write(9, 64'h9A);
    tick();
    idle();
    checks++;
    if (rd_pend !== 2'b00 || rd_data[127:64] !== 64'h9A) begin
      errors++; $display("FAIL pend_clear: got pend=%b data=%h expected 00/9a", rd_pend, rd_data[127:64]);
    end
    do_set(12);
    set_rd(12, 13);
    tick();
    idle();
    checks++;
    if (rd_pend !== 2'b01) begin
      errors++; $display("FAIL pend_port0_only: got %b expected 01", rd_pend);
    end
    do_set(13);
    do_write(12, 64'hC);
    tick();
    idle();
    checks++;
    if (rd_pend !== 2'b10) begin
      errors++; $display("FAIL pend_swap: got %b expected 10", rd_pend);
    end
    do_write(13, 64'hD);
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    do_write(10, 64'hA);
    set_rd(10, 11);
    tick();
    checks++;
    if (rd_data[63:0] !== 64'hA || rd_data[127:64] !== 64'h0) begin
      errors++; $display("FAIL b2b_first: got %h expected 0_a", rd_data);
    end
    do_write(11, 64'hB);
    tick();
    idle();
    checks++;
    if (rd_data[63:0] !== 64'hA || rd_data[127:64] !== 64'hB) begin
      errors++; $display("FAIL b2b_second: got %h expected b_a", rd_data);
    end
    set_rd(11, 10);
    tick();
    checks++;
    if (rd_data[63:0] !== 64'hB || rd_data[127:64] !== 64'hA) begin
      errors++; $display("FAIL b2b_third: got %h expected a_b", rd_data);
    end
  endtask

  task automatic test_reset_in_run();
    int n;
    do_write(3, 64'h3333);
    tick();
    idle();
    do_set(3);
    tick();
    idle();
    set_rd(3, 3);
    tick();
    checks++;
    if (rd_pend !== 2'b11 || rd_data[63:0] !== 64'h3333) begin
      errors++; $display("FAIL r3_setup: got pend=%b data=%h expected 11/3333", rd_pend, rd_data[63:0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (init_done !== 1'b0 || rd_data !== '0 || rd_pend !== 2'b00) begin
      errors++; $display("FAIL run_reset_outputs: got done=%b data=%h pend=%b expected 0/0/00", init_done, rd_data, rd_pend);
    end
    wait_init(n);
    checks++;
    if (n != 63) begin
      errors++; $display("FAIL run_reset_sweep: got %0d expected 63", n);
    end
    tick();
    checks++;
    if (rd_data !== '0 || rd_pend !== 2'b00) begin
      errors++; $display("FAIL r3_after_reset: got data=%h pend=%b expected 0/00", rd_data, rd_pend);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_rd(5, 7);
    for (int i = 0; i < 29; i++) tick();
    checks++;
    if (init_done !== 1'b0 || rd_data !== '0) begin
      errors++; $display("FAIL mid_sweep_state: got done=%b data=%h expected 0/0", init_done, rd_data);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_init(n);
    checks++;
    if (n != 63) begin
      errors++; $display("FAIL restart_sweep: got %0d expected 63", n);
    end
    tick();
    checks++;
    if (rd_data !== '0 || rd_pend !== 2'b00) begin
      errors++; $display("FAIL r5_r7_cleared: got data=%h pend=%b expected 0/00", rd_data, rd_pend);
    end
  endtask

  task automatic test_init_ignore();
    int n;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_write(4, 64'h55);
    do_set(4);
    set_rd(4, 4);
    wait_init(n);
    idle();
    checks++;
    if (rd_data !== '0 || rd_pend !== 2'b00) begin
      errors++; $display("FAIL init_outputs: got data=%h pend=%b expected 0/00", rd_data, rd_pend);
    end
    tick();
    checks++;
    if (rd_data !== '0 || rd_pend !== 2'b00) begin
      errors++; $display("FAIL r4_ignored: got data=%h pend=%b expected 0/00", rd_data, rd_pend);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_reset_in_run();
    test_reset_mid_sweep();
    test_init_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width in bits.
REQ-002 SHALL have parameter NREGS, default 64, number of architectural registers; power of two, >=4.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads zero, ignores writes and is never pending.
REQ-005 SHALL derive AW = log2(NREGS) as a localparam, not a port-visible parameter.
REQ-006 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 rd_rn  input  NRD*AW  read register numbers, port k in bits [k*AW +: AW].
REQ-009 rd_data  output  NRD*XLEN  registered read data, port k in bits [k*XLEN +: XLEN].
REQ-010 rd_pend  output  NRD  registered pending flag per read port, aligned with rd_data.
REQ-011 w_en  input  1  write-back enable; w_rn  input  AW  write register; w_data  input  XLEN  write data.
REQ-012 sb_set  input  1  mark register sb_rn pending (instruction issued); sb_rn  input  AW.
REQ-013 init_done  output  1  high once the post-reset clear sweep completes.

Function
REQ-014 SHALL implement FSM with states INIT and RUN; INIT entered on reset, RUN entered the cycle after the sweep writes entry NREGS-1.
REQ-015 In INIT, a sweep counter SHALL start at entry 1 (entry 0 if ZERO_REG=0) and write zero to one entry per cycle, incrementing by 1 per cycle.
REQ-016 In INIT, w_en and sb_set SHALL be ignored, every pending bit SHALL be held 0, and rd_data/rd_pend SHALL output 0.
REQ-017 init_done SHALL be 0 in INIT and 1 in RUN; sweep length is exactly NREGS-ZERO_REG cycles after rst_n deasserts.
REQ-018 In RUN, read latency SHALL be 1 cycle: rd_data[k] at edge N+1 reflects rd_rn[k] presented in cycle N.
REQ-019 Write-bypass: if w_en and w_rn==rd_rn[k] in the same cycle, rd_data[k] SHALL return w_data, not the stale entry.
REQ-020 If ZERO_REG=1 and rd_rn[k]==0, rd_data[k] and rd_pend[k] SHALL be 0 regardless of w_en/sb_set.
REQ-021 w_en with w_rn==0 and ZERO_REG=1 SHALL NOT modify storage or scoreboard.
REQ-022 Scoreboard: sb_set sets pend[sb_rn]; w_en clears pend[w_rn]; same register in the same cycle -> set wins (pend=1).
REQ-023 rd_pend[k] SHALL equal pend[rd_rn[k]] after the current cycle's set/clear updates (set/clear fully bypassed).
REQ-024 Any number of read ports SHALL read the same register in one cycle with identical results.
REQ-025 Write data SHALL be stored at full XLEN; no truncation or sign extension.

Reset
REQ-026 rst_n low at any clock edge SHALL force state INIT, sweep counter to first entry, init_done=0, rd_data=0, rd_pend=0, all pend bits=0.
REQ-027 Reset asserted mid-sweep or mid-RUN SHALL restart the full sweep; storage content is guaranteed only after init_done=1.
REQ-028 Storage array itself SHALL have no reset term (cleared only by the sweep) to allow block-RAM inference.

Structure
REQ-029 FSM state encoding (INIT, RUN) and the XLEN/NREGS defaults SHALL live in the shared raisin64 package.
REQ-030 Storage SHALL be a sub-module regfile_bank (1 write, 1 registered read, no reset), instantiated NRD times with write ports tied together.
REQ-031 Bypass, zero-register masking, scoreboard and FSM SHALL live in regfile_mp, outside regfile_bank.

Verification
REQ-032 Reset release, defaults: count cycles until init_done=1 -> exactly 63 cycles; every register reads 0, rd_pend=0.
REQ-033 RUN: write r5=0x0123_4567_89AB_CDEF, next cycle read r5 on both ports -> both rd_data = 0x0123_4567_89AB_CDEF one cycle later.
REQ-034 Same cycle w_en r7=0xDEAD and rd_rn[0]=7 -> rd_data[0]=0xDEAD next cycle; write r0=0xFFFF, read r0 -> 0, rd_pend=0.
REQ-035 sb_set r9, then read r9 -> rd_pend=1; w_en r9 with sb_set r9 same cycle -> rd_pend stays 1; w_en r9 alone -> rd_pend=0 on that read.
REQ-036 Pulse rst_n low for 1 cycle at sweep entry 30 and again in RUN with r3 pending -> init_done drops, full 63-cycle sweep restarts, r3 reads 0, rd_pend=0.
REQ-037 During INIT drive w_en r4=0x55 and sb_set r4 -> after init_done, r4 reads 0, rd_pend=0.
